uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
UART receiver at the far end of the baud-timing path. It runs a local 16x oversample tick from C_SYSTEM_FREQ/C_BAUDRATE, which it realigns on each start-bit edge. It samples serial frames mid-bit and presents each received byte through a one-entry valid/ready holding register. It flags framing and overrun errors for the AXI-Lite register wrapper above it.

Parameters:
C_BAUDRATE, 115200, line bit rate in bits/s
C_SYSTEM_FREQ, 50_000_000, clk frequency in Hz
C_DATA_BITS, 8, data bits per frame (5..8)
Derived: OS_DIV = C_SYSTEM_FREQ/(C_BAUDRATE*16), integer floor, must be >= 2; counter width $clog2(OS_DIV)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
rx_i  input  1  asynchronous serial line, idle high
rx_data_o  output  C_DATA_BITS  received byte, LSB = first bit on line
rx_valid_o  output  1  holding register full
rx_ready_i  input  1  consumer accepts byte when rx_valid_o && rx_ready_i
frame_err_o  output  1  stop bit of held byte sampled 0; qualified by rx_valid_o
parity_err_o  output  1  parity mismatch of held byte; tied 0 without UART_RX_PARITY_EN
overrun_err_o  output  1  one-cycle pulse when a completed byte is dropped
busy_o  output  1  FSM not in IDLE

Behaviour:
- Reset, asynchronous: FSM=IDLE; all counters, rx_data_o, rx_valid_o, frame_err_o, parity_err_o, overrun_err_o and busy_o = 0. Synchronizer flops reset to 1. Reset mid-frame abandons the frame; no partial byte is delivered.
- Input: 2-flop synchronizer to rx_s. All decisions use rx_s only.
- os_tick: 1-cycle pulse when os_cnt reaches OS_DIV-1, then os_cnt wraps to 0. os_cnt and tick_cnt (0..15) clear on the cycle IDLE->START is taken.
- IDLE: if rx_s==0 and armed, go to START. armed is set whenever rx_s==1 in IDLE.
- START: at tick_cnt==7 on os_tick (mid start bit): if rx_s==1, false start, go to IDLE. Otherwise clear tick_cnt, set bit_cnt=0 and go to DATA.
- DATA: on each os_tick with tick_cnt==15, shift rx_s into shift register MSB and shift right, then bit_cnt++. After C_DATA_BITS samples, go to STOP (or PARITY when the macro is enabled).
- STOP: on os_tick with tick_cnt==15, sample stop bit and commit, then go to IDLE.
  - If stop==0, clear armed. The receiver will not restart until the line returns high, so a break condition yields exactly one frame error.
- Commit, one cycle after the stop sample:
  - Holding register empty, or being accepted this same cycle: load data and error flags, rx_valid_o=1.
  - Holding register full and not accepted: drop the new byte, keep the old one, pulse overrun_err_o for 1 cycle.
- Handshake: rx_valid_o && rx_ready_i with no simultaneous commit clears rx_valid_o. rx_data_o, frame_err_o and parity_err_o hold until the next load.
- Latency: rx_valid_o rises 1 clk after the os_tick of the mid-stop-bit sample, i.e. about 9.5 bit times after the start edge plus 2 synchronizer cycles.

Optional Feature:
UART_RX_PARITY_EN: when defined, the FSM adds a PARITY state between DATA and STOP.
- The parity bit is sampled at mid-bit like a data bit.
- Even parity: parity_err_o = XOR(data bits, parity bit) for the held byte.
- When undefined, there is no PARITY state and parity_err_o is constant 0.

Test Plan:
All tests use C_SYSTEM_FREQ=1_600_000 and C_BAUDRATE=10_000, giving OS_DIV=10 and 160 clk per bit.
- Send 0xA5 (8N1) with rx_ready_i=1 -> rx_valid_o pulses 1 cycle with rx_data_o=0xA5; frame_err_o=0, overrun_err_o never asserted.
- Glitch rx_i low for 50 clk, then high -> false start: FSM returns to IDLE, rx_valid_o stays 0, busy_o deasserts by clk 120.
- Send 0x3C with stop bit driven 0, then hold line low 2 frames -> exactly one byte delivered, 0x3C with frame_err_o=1; no further frames until rx_i returns high.
- rx_ready_i=0, send 0x11 then 0x22 -> rx_data_o stays 0x11, overrun_err_o pulses once at the second commit. Then raise rx_ready_i -> rx_valid_o clears.
- Hold rx_ready_i so acceptance of 0x11 lands on the exact commit cycle of 0x22 -> rx_data_o=0x22, rx_valid_o stays 1, no overrun pulse.
- Assert resetn=0 mid-DATA of 0xFF, release, then send 0x5A -> only 0x5A delivered, no error flags. With UART_RX_PARITY_EN, sending 0x5A with odd parity bit -> parity_err_o=1.

Source files
------------

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_rx_core #(
  parameter int unsigned C_BAUDRATE    = 115200,
  parameter int unsigned C_SYSTEM_FREQ = 50_000_000,
  parameter int unsigned C_DATA_BITS   = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rx_i,
  output logic [C_DATA_BITS-1:0] rx_data_o,
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic                   frame_err_o,
  output logic                   parity_err_o,
  output logic                   overrun_err_o,
  output logic                   busy_o
);

  // OS_DIV must be at least 2 so the counter has a width.
  localparam int unsigned OS_DIV = C_SYSTEM_FREQ / (C_BAUDRATE * 16);
  localparam int unsigned OsW    = $clog2(OS_DIV);
  localparam int unsigned BcW    = $clog2(C_DATA_BITS);
  localparam logic [OsW-1:0] OsLast  = OsW'(OS_DIV - 1);
  localparam logic [BcW-1:0] BitLast = BcW'(C_DATA_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_RX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                 state_q, state_d;
  logic                   sync_q, rx_s_q;
  logic [OsW-1:0]         os_cnt_q, os_cnt_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [BcW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [C_DATA_BITS-1:0] shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic [C_DATA_BITS-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   frame_q, frame_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   perr_q, perr_d;
`endif

  logic os_tick, mid_tick, end_tick, commit;

  assign os_tick  = (os_cnt_q == OsLast);
  assign mid_tick = os_tick && (tick_cnt_q == 4'd7);
  assign end_tick = os_tick && (tick_cnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_tick ? '0 : os_cnt_q + 1'b1;
    tick_cnt_d = os_tick ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    commit     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // Realign the oversample grid to the start edge.
          state_d    = StStart;
          os_cnt_d   = '0;
          tick_cnt_d = '0;
        end
      end
      StStart: begin
        if (mid_tick) begin
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
          end
        end
      end
      StData: begin
        if (end_tick) begin
          shift_d   = {rx_s_q, shift_q[C_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (end_tick) begin
          par_bit_d = rx_s_q;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (end_tick) begin
          commit  = 1'b1;
          state_d = StIdle;
          // A low stop bit disarms until the line idles high, so a break gives one error.
          if (!rx_s_q) armed_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    data_d    = data_q;
    valid_d   = valid_q;
    frame_d   = frame_q;
    overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = perr_q;
`endif
    if (commit) begin
      if (!valid_q || rx_ready_i) begin
        data_d  = shift_q;
        frame_d = !rx_s_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        perr_d  = ^{shift_q, par_bit_q};
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready_i) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= StIdle;
      os_cnt_q   <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frame_q    <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      sync_q     <= rx_i;
      rx_s_q     <= sync_q;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frame_q    <= frame_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data_o     = data_q;
  assign rx_valid_o    = valid_q;
  assign frame_err_o   = frame_q;
  assign overrun_err_o = overrun_q;
  assign busy_o        = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o  = perr_q;
`else
  assign parity_err_o  = 1'b0;
`endif

endmodule
